// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, state encoding and queue entry type for instruction fetch
package fetch_pkg;

    localparam int DEFAULT_ADDR_W  = 12;
    localparam int DEFAULT_INSTR_W = 19;
    localparam int DEFAULT_DEPTH   = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [DEFAULT_ADDR_W-1:0]  pc;
        logic [DEFAULT_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - circular prefetch queue with push, pop, flush and occupancy count
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = DEFAULT_DEPTH,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  entry_t                       push_data,
    input  logic                         pop,
    input  logic                         flush,
    output entry_t                       head_data,
    output logic                         head_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    entry_t          mem [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic            do_push;
    logic            do_pop;

    // Pointers wrap at DEPTH-1 so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    // A flush overrides any push or pop requested in the same cycle.
    assign do_pop     = pop && (count != '0) && !flush;
    assign do_push    = push && !flush && ((count != CW'(DEPTH)) || do_pop);
    assign head_valid = (count != '0);
    assign head_data  = head_valid ? mem[head] : '0;

    // Entry storage; contents only matter between push and pop, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[tail] <= push_data;
        end
    end

    // Head/tail pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                tail <= bump(tail);
            end
            if (do_pop) begin
                head <= bump(head);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch sequencer: PC stream, prefetch queue, redirect flush
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = DEFAULT_ADDR_W,
    parameter int                INSTR_W  = DEFAULT_INSTR_W,
    parameter int                DEPTH    = DEFAULT_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    output logic [ADDR_W-1:0]            imem_addr,
    input  logic [INSTR_W-1:0]           imem_data,
    output logic [INSTR_W-1:0]           instr,
    output logic [ADDR_W-1:0]            instr_pc,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    input  logic                         redirect,
    input  logic [ADDR_W-1:0]            redirect_pc,
    output logic [$clog2(DEPTH+1)-1:0]   q_count
);

    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    fetch_state_e        state_q;
    fetch_state_e        state_d;
    logic [ADDR_W-1:0]   fetch_pc;
    logic [ADDR_W-1:0]   pend_pc;
    logic [1:0]          outstanding;
    logic [CW:0]         in_use;
    logic                issue;
    logic                ret;
    logic                push;
    entry_t              push_data;
    entry_t              head_data;
    logic                head_valid;

    // State register: RUN only gates issuing, the queue is untouched by it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and issue decision; queued plus in-flight words never exceed DEPTH.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        in_use  = (CW+1)'(q_count) + (CW+1)'(outstanding);
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!en) begin
                    state_d = IDLE;
                end
                issue = !redirect && (in_use < (CW+1)'(DEPTH));
            end
        endcase
    end

    // Memory answers one cycle after issue, so every in-flight word returns in the
    // redirect cycle itself; suppressing the push there is what drops stale words.
    assign ret       = (outstanding != '0);
    assign push      = ret && !redirect;
    assign imem_addr = fetch_pc;

    assign push_data.pc    = pend_pc;
    assign push_data.instr = imem_data;

    // Fetch PC, in-flight count and the PC of the word currently on imem_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            pend_pc     <= '0;
            outstanding <= '0;
        end else begin
            outstanding <= outstanding + 2'(issue) - 2'(ret);
            if (issue) begin
                pend_pc <= fetch_pc;
            end
            if (redirect) begin
                fetch_pc <= redirect_pc;
            end else if (issue) begin
                fetch_pc <= fetch_pc + ADDR_W'(1);
            end
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (push_data),
        .pop        (instr_ready),
        .flush      (redirect),
        .head_data  (head_data),
        .head_valid (head_valid),
        .count      (q_count)
    );

    assign instr       = head_data.instr;
    assign instr_pc    = head_data.pc;
    assign instr_valid = head_valid;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - randomized and directed bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        instr_ready;
    logic        redirect;
    logic [11:0] redirect_pc;
    logic [11:0] imem_addr;
    logic [18:0] imem_data;
    logic [18:0] instr;
    logic [11:0] instr_pc;
    logic        instr_valid;
    logic [2:0]  q_count;

    int total = 0;
    int bad   = 0;

    logic [18:0] mem [4096];

    typedef struct {
        logic [11:0] pc;
        logic [18:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [11:0] infl[$];
    logic [11:0] mpc;
    bit          mrun;

    instruction_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .q_count     (q_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_data <= mem[imem_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        infl.delete();
        mpc  = 12'h000;
        mrun = 1'b0;
    endtask

    task automatic model_step();
        bit          pop;
        bit          iss;
        logic [11:0] p;
        ent_t        e;
        pop = (mq.size() > 0) && instr_ready;
        if (redirect) begin
            mq.delete();
            infl.delete();
            mpc = redirect_pc;
        end else begin
            iss = mrun && ((mq.size() + infl.size()) < DEPTH);
            if (pop) void'(mq.pop_front());
            while (infl.size() > 0) begin
                p = infl.pop_front();
                e.pc = p;
                e.instr = mem[p];
                mq.push_back(e);
            end
            if (iss) begin
                infl.push_back(mpc);
                mpc = mpc + 12'h001;
            end
        end
        mrun = en;
    endtask

    task automatic compare();
        chk("imem_addr", 32'(imem_addr), 32'(mpc));
        chk("instr_valid", 32'(instr_valid), 32'(mq.size() != 0));
        chk("q_count", 32'(q_count), 32'(mq.size()));
        if (mq.size() != 0) begin
            chk("instr_pc", 32'(instr_pc), 32'(mq[0].pc));
            chk("instr", 32'(instr), 32'(mq[0].instr));
        end
    endtask

    task automatic cycle(input bit e, input bit r, input bit rd, input logic [11:0] rp);
        en          = e;
        instr_ready = r;
        redirect    = rd;
        redirect_pc = rp;
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic wait_valid(input bit rd, input logic [11:0] rp, output int n);
        cycle(1'b1, 1'b1, rd, rp);
        n = 1;
        while (!instr_valid && n < 10) begin
            cycle(1'b1, 1'b1, 1'b0, 12'h000);
            n++;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_addr"}, 32'(imem_addr), 32'h000);
        chk({tag, "_valid"}, 32'(instr_valid), 32'h0);
        chk({tag, "_instr"}, 32'(instr), 32'h0);
        chk({tag, "_pc"}, 32'(instr_pc), 32'h000);
        chk({tag, "_qcount"}, 32'(q_count), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [11:0] wrap_seq [4];
        logic [11:0] rp;
        wrap_seq[0] = 12'hFFE;
        wrap_seq[1] = 12'hFFF;
        wrap_seq[2] = 12'h000;
        wrap_seq[3] = 12'h001;

        for (int k = 0; k < 4096; k++) mem[k] = 19'(k + 32'h100);
        rst = 1'b1; en = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_reset_vals("reset");

        // en rise from reset: first valid three cycles later, then a steady stream
        wait_valid(1'b0, 12'h000, n);
        chk("en_latency", 32'(n), 32'd3);
        chk("first_pc", 32'(instr_pc), 32'h000);
        repeat (12) cycle(1'b1, 1'b1, 1'b0, 12'h000);

        // back-pressure: queue saturates, then drains in order
        repeat (10) cycle(1'b1, 1'b0, 1'b0, 12'h000);
        chk("q_full", 32'(q_count), 32'(DEPTH));
        repeat (10) cycle(1'b1, 1'b1, 1'b0, 12'h000);

        // redirect with a partly full queue
        repeat (2) cycle(1'b1, 1'b0, 1'b0, 12'h000);
        wait_valid(1'b1, 12'h7F0, n);
        chk("redir_latency", 32'(n), 32'd3);
        chk("redir_pc", 32'(instr_pc), 32'h7F0);

        // PC wrap
        wait_valid(1'b1, 12'hFFE, n);
        chk("wrap_latency", 32'(n), 32'd3);
        chk("wrap_0", 32'(instr_pc), 32'(wrap_seq[0]));
        for (int i = 1; i < 4; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 12'h000);
            chk($sformatf("wrap_%0d", i), 32'(instr_pc), 32'(wrap_seq[i]));
        end

        // redirect with a pop in the same cycle, then back-to-back redirects
        cycle(1'b1, 1'b1, 1'b1, 12'h100);
        wait_valid(1'b1, 12'h200, n);
        chk("b2b_latency", 32'(n), 32'd3);
        chk("b2b_pc", 32'(instr_pc), 32'h200);
        repeat (4) cycle(1'b1, 1'b1, 1'b0, 12'h000);

        // asynchronous reset mid-stream
        #2 rst = 1'b1;
        #1 chk_reset_vals("async");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_valid(1'b0, 12'h000, n);
        chk("restart_latency", 32'(n), 32'd3);
        chk("restart_pc", 32'(instr_pc), 32'h000);

        // randomized traffic against the model with random memory contents
        rst = 1'b1;
        for (int k = 0; k < 4096; k++) mem[k] = 19'($urandom);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 500; i++) begin
            rp = ($urandom_range(0, 3) == 0) ? (12'hFFC + 12'($urandom_range(0, 3))) : 12'($urandom);
            cycle($urandom_range(0, 9) != 0,
                  $urandom_range(0, 2) != 0,
                  $urandom_range(0, 15) == 0,
                  rp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
